// File: rtl/bus_sequencer.sv
// Table-driven bus sequencer: walks a WRITE/POLL/DELAY/END program looked up by
// prog_idx and issues one single-beat transaction at a time on an AXI-lite style bus.
module bus_sequencer #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int POLL_MAX = 1024,
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PCW     = $clog2(POLL_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [IW-1:0] prog_idx,
    input  logic [1:0]    op_type,
    input  logic [AW-1:0] op_addr,
    input  logic [DW-1:0] op_data,
    input  logic [DW-1:0] op_mask,
    output logic [AW-1:0] aw_addr,
    output logic          aw_valid,
    input  logic          aw_ready,
    output logic [DW-1:0] w_data,
    output logic          w_valid,
    input  logic          w_ready,
    input  logic [1:0]    b_resp,
    input  logic          b_valid,
    output logic          b_ready,
    output logic [AW-1:0] ar_addr,
    output logic          ar_valid,
    input  logic          ar_ready,
    input  logic [DW-1:0] r_data,
    input  logic [1:0]    r_resp,
    input  logic          r_valid,
    output logic          r_ready,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [IW-1:0] err_idx,
    output logic [DW-1:0] last_rdata
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_EXEC  = 4'd1;
    localparam logic [3:0] S_WADDR = 4'd2;
    localparam logic [3:0] S_WRESP = 4'd3;
    localparam logic [3:0] S_RADDR = 4'd4;
    localparam logic [3:0] S_RRESP = 4'd5;
    localparam logic [3:0] S_DELAY = 4'd6;
    localparam logic [3:0] S_DONE  = 4'd7;
    localparam logic [3:0] S_ERR   = 4'd8;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_POLL  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    localparam logic [1:0] E_BRESP   = 2'b01;
    localparam logic [1:0] E_RRESP   = 2'b10;
    localparam logic [1:0] E_TIMEOUT = 2'b11;

    logic [3:0]     state_q, state_d;
    logic [IW-1:0]  prog_idx_q, prog_idx_d;
    logic           aw_valid_q, aw_valid_d;
    logic           w_valid_q, w_valid_d;
    logic           ar_valid_q, ar_valid_d;
    logic [AW-1:0]  aw_addr_q, aw_addr_d;
    logic [DW-1:0]  w_data_q, w_data_d;
    logic [AW-1:0]  ar_addr_q, ar_addr_d;
    logic [DW-1:0]  dly_q, dly_d;
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
    logic [1:0]     err_code_q, err_code_d;
    logic [IW-1:0]  err_idx_q, err_idx_d;
    logic [DW-1:0]  last_rdata_q, last_rdata_d;
    logic           b_ready_q, r_ready_q, busy_q, done_q, error_q;

    logic           last_entry_s;
    logic [IW-1:0]  idx_next_s;
    logic [3:0]     adv_state_s;
    logic           poll_match_s;
    logic [PCW-1:0] poll_inc_s;

    // Advancing from the final entry ends the program instead of wrapping.
    assign last_entry_s = (prog_idx_q == IW'(DEPTH - 1));
    assign idx_next_s   = last_entry_s ? prog_idx_q : (prog_idx_q + IW'(1));
    assign adv_state_s  = last_entry_s ? S_DONE : S_EXEC;
    assign poll_match_s = (((r_data ^ op_data) & op_mask) == {DW{1'b0}});
    assign poll_inc_s   = poll_cnt_q + PCW'(1);

    // Next-state and datapath decode for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        prog_idx_d   = prog_idx_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        ar_valid_d   = ar_valid_q;
        aw_addr_d    = aw_addr_q;
        w_data_d     = w_data_q;
        ar_addr_d    = ar_addr_q;
        dly_d        = dly_q;
        poll_cnt_d   = poll_cnt_q;
        err_code_d   = err_code_q;
        err_idx_d    = err_idx_q;
        last_rdata_d = last_rdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_EXEC;
                    prog_idx_d = {IW{1'b0}};
                    poll_cnt_d = {PCW{1'b0}};
                    err_code_d = 2'b00;
                end else begin
                    state_d = state_q;
                end
            end
            S_EXEC: begin
                case (op_type)
                    OP_WRITE: begin
                        state_d    = S_WADDR;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        aw_addr_d  = op_addr;
                        w_data_d   = op_data;
                    end
                    OP_POLL: begin
                        state_d    = S_RADDR;
                        ar_valid_d = 1'b1;
                        ar_addr_d  = op_addr;
                    end
                    OP_DELAY: begin
                        state_d = S_DELAY;
                        dly_d   = op_data;
                    end
                    OP_END:  state_d = S_DONE;
                    default: state_d = S_DONE;
                endcase
            end
            S_WADDR: begin
                // Address and data channels retire independently; leave once both are taken.
                aw_valid_d = aw_valid_q & ~aw_ready;
                w_valid_d  = w_valid_q & ~w_ready;
                if ((!aw_valid_q || aw_ready) && (!w_valid_q || w_ready)) begin
                    state_d = S_WRESP;
                end else begin
                    state_d = S_WADDR;
                end
            end
            S_WRESP: begin
                if (b_valid && (b_resp == 2'b00)) begin
                    state_d    = adv_state_s;
                    prog_idx_d = idx_next_s;
                end else if (b_valid) begin
                    state_d    = S_ERR;
                    err_code_d = E_BRESP;
                    err_idx_d  = prog_idx_q;
                end else begin
                    state_d = S_WRESP;
                end
            end
            S_RADDR: begin
                if (ar_ready) begin
                    ar_valid_d = 1'b0;
                    state_d    = S_RRESP;
                end else begin
                    state_d = S_RADDR;
                end
            end
            S_RRESP: begin
                if (r_valid) begin
                    last_rdata_d = r_data;
                    if (r_resp != 2'b00) begin
                        state_d    = S_ERR;
                        err_code_d = E_RRESP;
                        err_idx_d  = prog_idx_q;
                    end else if (poll_match_s) begin
                        poll_cnt_d = {PCW{1'b0}};
                        state_d    = adv_state_s;
                        prog_idx_d = idx_next_s;
                    end else if (poll_inc_s == PCW'(POLL_MAX)) begin
                        poll_cnt_d = poll_inc_s;
                        state_d    = S_ERR;
                        err_code_d = E_TIMEOUT;
                        err_idx_d  = prog_idx_q;
                    end else begin
                        poll_cnt_d = poll_inc_s;
                        state_d    = S_EXEC;
                    end
                end else begin
                    state_d = S_RRESP;
                end
            end
            S_DELAY: begin
                if (dly_q == {DW{1'b0}}) begin
                    state_d    = adv_state_s;
                    prog_idx_d = idx_next_s;
                end else begin
                    dly_d = dly_q - DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; handshake readies and flags are registered from state_d.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prog_idx_q   <= {IW{1'b0}};
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            ar_valid_q   <= 1'b0;
            aw_addr_q    <= {AW{1'b0}};
            w_data_q     <= {DW{1'b0}};
            ar_addr_q    <= {AW{1'b0}};
            dly_q        <= {DW{1'b0}};
            poll_cnt_q   <= {PCW{1'b0}};
            err_code_q   <= 2'b00;
            err_idx_q    <= {IW{1'b0}};
            last_rdata_q <= {DW{1'b0}};
            b_ready_q    <= 1'b0;
            r_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prog_idx_q   <= prog_idx_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            ar_valid_q   <= ar_valid_d;
            aw_addr_q    <= aw_addr_d;
            w_data_q     <= w_data_d;
            ar_addr_q    <= ar_addr_d;
            dly_q        <= dly_d;
            poll_cnt_q   <= poll_cnt_d;
            err_code_q   <= err_code_d;
            err_idx_q    <= err_idx_d;
            last_rdata_q <= last_rdata_d;
            b_ready_q    <= (state_d == S_WRESP);
            r_ready_q    <= (state_d == S_RRESP);
            busy_q       <= !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERR);
        end
    end

    assign prog_idx   = prog_idx_q;
    assign aw_addr    = aw_addr_q;
    assign aw_valid   = aw_valid_q;
    assign w_data     = w_data_q;
    assign w_valid    = w_valid_q;
    assign b_ready    = b_ready_q;
    assign ar_addr    = ar_addr_q;
    assign ar_valid   = ar_valid_q;
    assign r_ready    = r_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;
    assign err_idx    = err_idx_q;
    assign last_rdata = last_rdata_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: program table, behavioural responder, a program-level
// reference model, and per-cycle protocol checks, all run from one driving process.
module tb_bus_sequencer;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int DEPTH    = 32;
    localparam int POLL_MAX = 4;
    localparam int IW       = 5;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [IW-1:0] prog_idx;
    logic [1:0]    op_type;
    logic [AW-1:0] op_addr, aw_addr, ar_addr;
    logic [DW-1:0] op_data, op_mask, w_data, r_data, last_rdata;
    logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic          ar_valid, ar_ready, r_valid, r_ready, busy, done, error;
    logic [1:0]    b_resp, r_resp, err_code;
    logic [IW-1:0] err_idx;

    always #5 clk = ~clk;

    logic [1:0]    p_type [0:DEPTH-1];
    logic [AW-1:0] p_addr [0:DEPTH-1];
    logic [DW-1:0] p_data [0:DEPTH-1];
    logic [DW-1:0] p_mask [0:DEPTH-1];

    assign op_type = p_type[prog_idx];
    assign op_addr = p_addr[prog_idx];
    assign op_data = p_data[prog_idx];
    assign op_mask = p_mask[prog_idx];

    bus_sequencer #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_idx(prog_idx),
        .op_type(op_type), .op_addr(op_addr), .op_data(op_data), .op_mask(op_mask),
        .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .err_idx(err_idx), .last_rdata(last_rdata)
    );

    int tests = 0;
    int fails = 0;

    // Responder configuration and observation.
    logic [1:0]    bresp_tab [0:15];
    logic [1:0]    rresp_tab [0:15];
    logic [DW-1:0] rdata_tab [0:15];
    int            aw_delay, w_delay, aw_wait, w_wait;
    logic          r_hold;
    int            aw_n, w_n, b_n, ar_n, r_n, aw_vc, w_vc;
    logic [AW-1:0] lg_wa [0:15];
    logic [DW-1:0] lg_wd [0:15];
    logic [AW-1:0] lg_ra [0:15];
    int            busy_cyc [0:DEPTH-1];
    logic          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [AW-1:0] p_awa, p_ara;
    logic [DW-1:0] p_wd;

    // Reference model results.
    logic [AW-1:0] m_wa [0:15];
    logic [DW-1:0] m_wd [0:15];
    logic [AW-1:0] m_ra [0:15];
    int            m_nw, m_nr, m_idx, m_eidx;
    logic          m_done, m_err;
    logic [1:0]    m_code;
    logic [DW-1:0] m_last, last_keep;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Walk the program as the responder will answer it, entry by entry.
    task automatic model_run();
        int  idx;
        int  pc;
        bit  fin;
        bit  adv;
        logic [DW-1:0] rd;
        idx = 0; pc = 0; fin = 1'b0;
        m_nw = 0; m_nr = 0; m_done = 1'b0; m_err = 1'b0; m_code = 2'b00; m_eidx = 0;
        m_last = last_keep;
        while (!fin) begin
            adv = 1'b0;
            case (p_type[idx])
                2'b00: begin
                    m_wa[m_nw] = p_addr[idx];
                    m_wd[m_nw] = p_data[idx];
                    if (bresp_tab[m_nw] != 2'b00) begin m_err = 1'b1; m_code = 2'b01; end
                    else adv = 1'b1;
                    m_nw++;
                end
                2'b01: begin
                    m_ra[m_nr] = p_addr[idx];
                    rd = rdata_tab[m_nr];
                    m_last = rd;
                    if (rresp_tab[m_nr] != 2'b00) begin m_err = 1'b1; m_code = 2'b10; end
                    else if ((rd & p_mask[idx]) == (p_data[idx] & p_mask[idx])) begin adv = 1'b1; pc = 0; end
                    else begin
                        pc++;
                        if (pc == POLL_MAX) begin m_err = 1'b1; m_code = 2'b11; end
                    end
                    m_nr++;
                end
                2'b10:   adv = 1'b1;
                default: m_done = 1'b1;
            endcase
            if (m_err) begin m_eidx = idx; fin = 1'b1; end
            else if (m_done) fin = 1'b1;
            else if (adv) begin
                if (idx == DEPTH - 1) begin m_done = 1'b1; fin = 1'b1; end
                else idx++;
            end
            if (m_nw >= 16 || m_nr >= 16) fin = 1'b1;
        end
        m_idx = idx;
    endtask

    task automatic check_cycle();
        chk("aw_ar_exclusive", 64'((aw_valid | w_valid) & ar_valid), 64'd0);
        chk("flags_onehot0", 64'($onehot0({busy, done, error})), 64'd1);
        if (!busy) chk("idle_quiet", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready}), 64'd0);
        if (!rst && p_awv && !p_awr) chk("aw_hold", 64'({aw_valid, aw_addr}), 64'({1'b1, p_awa}));
        if (!rst && p_wv && !p_wr)   chk("w_hold", 64'({w_valid, w_data}), 64'({1'b1, p_wd}));
        if (!rst && p_arv && !p_arr) chk("ar_hold", 64'({ar_valid, ar_addr}), 64'({1'b1, p_ara}));
        if (busy) busy_cyc[prog_idx]++;
        if (aw_valid) aw_vc++;
        if (w_valid) w_vc++;
    endtask

    task automatic respond();
        if (aw_valid) begin
            if (aw_wait >= aw_delay) begin
                aw_ready = 1'b1; aw_wait = 0;
                if (aw_n < 16) begin lg_wa[aw_n] = aw_addr; chk("sb_aw_addr", 64'(aw_addr), 64'(m_wa[aw_n])); end
                aw_n++;
            end else begin aw_ready = 1'b0; aw_wait++; end
        end else begin aw_ready = 1'b0; aw_wait = 0; end
        if (w_valid) begin
            if (w_wait >= w_delay) begin
                w_ready = 1'b1; w_wait = 0;
                if (w_n < 16) begin lg_wd[w_n] = w_data; chk("sb_w_data", 64'(w_data), 64'(m_wd[w_n])); end
                w_n++;
            end else begin w_ready = 1'b0; w_wait++; end
        end else begin w_ready = 1'b0; w_wait = 0; end
        if (b_ready && aw_n > b_n && w_n > b_n) begin
            b_valid = 1'b1; b_resp = (b_n < 16) ? bresp_tab[b_n] : 2'b00; b_n++;
        end else begin b_valid = 1'b0; b_resp = 2'b00; end
        if (ar_valid) begin
            ar_ready = 1'b1;
            if (ar_n < 16) begin lg_ra[ar_n] = ar_addr; chk("sb_ar_addr", 64'(ar_addr), 64'(m_ra[ar_n])); end
            ar_n++;
        end else ar_ready = 1'b0;
        if (r_ready && ar_n > r_n && !r_hold && r_n < 16) begin
            r_valid = 1'b1; r_data = rdata_tab[r_n]; r_resp = rresp_tab[r_n]; r_n++;
        end else begin r_valid = 1'b0; r_data = '0; r_resp = 2'b00; end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        if (rst) begin
            aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; ar_ready = 1'b0; r_valid = 1'b0;
            aw_wait = 0; w_wait = 0; aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        end else respond();
        p_awv = aw_valid; p_awr = aw_ready; p_awa = aw_addr;
        p_wv = w_valid;   p_wr = w_ready;   p_wd = w_data;
        p_arv = ar_valid; p_arr = ar_ready; p_ara = ar_addr;
    endtask

    task automatic clear_all();
        for (int i = 0; i < DEPTH; i++) begin
            p_type[i] = 2'b11; p_addr[i] = '0; p_data[i] = '0; p_mask[i] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            bresp_tab[i] = 2'b00; rresp_tab[i] = 2'b00; rdata_tab[i] = '0;
        end
        aw_delay = 0; w_delay = 0; r_hold = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [1:0] t, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
        p_type[i] = t; p_addr[i] = a; p_data[i] = d; p_mask[i] = m;
    endtask

    task automatic begin_run();
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; aw_vc = 0; w_vc = 0;
        aw_wait = 0; w_wait = 0;
        for (int i = 0; i < DEPTH; i++) busy_cyc[i] = 0;
        model_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_prog(input int budget);
        int n;
        n = 0;
        begin_run();
        while (busy && n < budget) begin tick(); n++; end
        chk("run_terminates", 64'(busy), 64'd0);
        chk("done", 64'(done), 64'(m_done));
        chk("error", 64'(error), 64'(m_err));
        chk("prog_idx", 64'(prog_idx), 64'(m_idx));
        chk("last_rdata", 64'(last_rdata), 64'(m_last));
        chk("aw_beats", 64'(aw_n), 64'(m_nw));
        chk("w_beats", 64'(w_n), 64'(m_nw));
        chk("b_beats", 64'(b_n), 64'(m_nw));
        chk("ar_beats", 64'(ar_n), 64'(m_nr));
        if (m_err) begin
            chk("err_code", 64'(err_code), 64'(m_code));
            chk("err_idx", 64'(err_idx), 64'(m_eidx));
        end
        last_keep = m_last;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        last_keep = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
        p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0; p_arv = 1'b0; p_arr = 1'b0;
        p_awa = '0; p_wd = '0; p_ara = '0;
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; aw_vc = 0; w_vc = 0;
        for (int i = 0; i < DEPTH; i++) busy_cyc[i] = 0;
        clear_all();
        do_reset();
        chk("reset_flags", 64'({busy, done, error, aw_valid, w_valid, ar_valid, b_ready, r_ready}), 64'd0);
        chk("reset_regs", 64'({prog_idx, err_code, err_idx}), 64'd0);
        chk("reset_rdata", 64'(last_rdata), 64'd0);

        // Two writes then END, always-ready responder.
        clear_all();
        set_op(0, 2'b00, 32'h0001_0000, 32'h0000_0A2C, 32'h0);
        set_op(1, 2'b00, 32'h0001_001C, 32'h0000_0020, 32'h0);
        run_prog(100);
        chk("wr0_addr_lit", 64'(lg_wa[0]), 64'h0001_0000);
        chk("wr0_data_lit", 64'(lg_wd[0]), 64'h0000_0A2C);
        chk("wr1_addr_lit", 64'(lg_wa[1]), 64'h0001_001C);
        chk("wr1_data_lit", 64'(lg_wd[1]), 64'h0000_0020);
        chk("wr_done_idx_lit", 64'({done, prog_idx}), 64'({1'b1, 5'd2}));
        chk("wr_entry_cycles_lit", 64'(busy_cyc[0]), 64'd3);

        // Slow address channel, immediate data channel.
        clear_all();
        aw_delay = 3;
        set_op(0, 2'b00, 32'h0000_0200, 32'h0000_0055, 32'h0);
        run_prog(100);
        chk("aw_valid_cycles_lit", 64'(aw_vc), 64'd4);
        chk("w_valid_cycles_lit", 64'(w_vc), 64'd1);
        chk("one_wresp_lit", 64'(b_n), 64'd1);

        // Poll until masked bit clears.
        clear_all();
        set_op(0, 2'b01, 32'h0001_0014, 32'h0, 32'h2);
        rdata_tab[0] = 32'h2; rdata_tab[1] = 32'h2; rdata_tab[2] = 32'h0;
        run_prog(200);
        chk("poll_reads_lit", 64'(ar_n), 64'd3);
        chk("poll_last_lit", 64'(last_rdata), 64'd0);
        chk("poll_advance_lit", 64'(prog_idx), 64'd1);
        chk("poll_addr_lit", 64'(lg_ra[2]), 64'h0001_0014);

        // Mask-0 read, assorted delays, then a poll that never matches at entry 5.
        clear_all();
        set_op(0, 2'b01, 32'h0000_0040, 32'h0000_1234, 32'h0);
        set_op(1, 2'b10, 32'h0, 32'd0, 32'h0);
        set_op(2, 2'b10, 32'h0, 32'd1, 32'h0);
        set_op(3, 2'b10, 32'h0, 32'd2, 32'h0);
        set_op(4, 2'b10, 32'h0, 32'd0, 32'h0);
        set_op(5, 2'b01, 32'h0000_0044, 32'h55, 32'hFF);
        rdata_tab[0] = 32'hDEAD; rdata_tab[1] = 32'h00; rdata_tab[2] = 32'h54;
        rdata_tab[3] = 32'hAA;   rdata_tab[4] = 32'h00;
        run_prog(300);
        chk("timeout_reads_lit", 64'(ar_n), 64'd5);
        chk("timeout_err_lit", 64'({error, err_code, err_idx}), 64'({1'b1, 2'b11, 5'd5}));

        // Bad write response on entry 1, then rerun from index 0.
        clear_all();
        set_op(0, 2'b00, 32'h0000_0100, 32'h1, 32'h0);
        set_op(1, 2'b00, 32'h0000_0104, 32'h2, 32'h0);
        set_op(2, 2'b00, 32'h0000_0108, 32'h3, 32'h0);
        bresp_tab[1] = 2'b10;
        run_prog(100);
        chk("bresp_err_lit", 64'({error, err_code, err_idx}), 64'({1'b1, 2'b01, 5'd1}));
        for (int i = 0; i < 5; i++) tick();
        chk("bresp_quiet_lit", 64'(aw_n + ar_n), 64'd2);
        bresp_tab[1] = 2'b00;
        run_prog(100);
        chk("rerun_first_addr_lit", 64'(lg_wa[0]), 64'h0000_0100);
        chk("rerun_done_lit", 64'({done, error, prog_idx}), 64'({1'b1, 1'b0, 5'd3}));

        // Bad read response.
        clear_all();
        set_op(0, 2'b01, 32'h0000_0300, 32'h0, 32'h0);
        rresp_tab[0] = 2'b10; rdata_tab[0] = 32'h77;
        run_prog(100);
        chk("rresp_err_lit", 64'({error, err_code, last_rdata[7:0]}), 64'({1'b1, 2'b10, 8'h77}));

        // No END anywhere: finishing entry DEPTH-1 ends the program.
        clear_all();
        for (int i = 0; i < DEPTH; i++) set_op(i, 2'b10, 32'h0, 32'd0, 32'h0);
        run_prog(500);
        chk("no_wrap_lit", 64'({done, prog_idx}), 64'({1'b1, 5'd31}));

        // Reset while waiting for read data.
        clear_all();
        set_op(0, 2'b01, 32'h0000_0400, 32'h1, 32'h1);
        r_hold = 1'b1;
        begin_run();
        for (int i = 0; i < 20 && !r_ready; i++) tick();
        chk("reached_rresp", 64'({r_ready, ar_n[3:0]}), 64'({1'b1, 4'd1}));
        rst = 1'b1;
        tick();
        chk("mid_rst_quiet", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready, busy, done, error}), 64'd0);
        chk("mid_rst_idx", 64'(prog_idx), 64'd0);
        rst = 1'b0;
        r_hold = 1'b0;
        last_keep = '0;

        // Delay timing: entry cycles = EXEC + (N+1) DELAY cycles.
        clear_all();
        set_op(0, 2'b10, 32'h0, 32'd0, 32'h0);
        set_op(1, 2'b10, 32'h0, 32'd3, 32'h0);
        run_prog(100);
        chk("delay0_cycles_lit", 64'(busy_cyc[0] - 1), 64'd1);
        chk("delay3_cycles_lit", 64'(busy_cyc[1] - 1), 64'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameters, one per line:
  AW  32  address width
  DW  32  data width
  DEPTH  32  program entries; IW = $clog2(DEPTH)
  POLL_MAX  1024  poll attempts before timeout, >= 1
REQ-002 SHALL have ports, one per line:
  clk  in  1  clock
  rst  in  1  synchronous reset, active-high
  start  in  1  run-program pulse
  prog_idx  out  IW  program entry index
  op_type  in  2  entry type: 00 WRITE, 01 POLL, 10 DELAY, 11 END
  op_addr  in  AW  entry address
  op_data  in  DW  write data, poll compare value, or delay count
  op_mask  in  DW  poll mask
  aw_addr/aw_valid/aw_ready  out/out/in  AW/1/1  write address channel
  w_data/w_valid/w_ready  out/out/in  DW/1/1  write data channel
  b_resp/b_valid/b_ready  in/in/out  2/1/1  write response channel
  ar_addr/ar_valid/ar_ready  out/out/in  AW/1/1  read address channel
  r_data/r_resp/r_valid/r_ready  in/in/in/out  DW/2/1/1  read data channel
  busy  out  1  program running
  done  out  1  program finished cleanly; level
  error  out  1  program aborted; level
  err_code  out  2  01 bad BRESP, 10 bad RRESP, 11 poll timeout
  err_idx  out  IW  index of the failing entry
  last_rdata  out  DW  data of the most recent read beat
REQ-003 SHALL use one clock, clk; the synchronous active-high reset rst SHALL be the only reset.

Function
REQ-004 The program source (op_*) SHALL be a combinational lookup of prog_idx, sampled in EXEC.
REQ-005 States SHALL be IDLE, EXEC, WADDR, WRESP, RADDR, RRESP, DELAY, DONE, ERR.
REQ-006 IDLE/DONE/ERR: start=1 SHALL go to EXEC with prog_idx=0, poll count=0, done=0, error=0; start SHALL be ignored in all other states.
REQ-007 EXEC SHALL decode within one cycle: WRITE->WADDR; POLL->RADDR; DELAY->DELAY, loading the counter with op_data; END->DONE.
REQ-008 WADDR SHALL assert aw_valid and w_valid together, with addr/data captured from the entry; each valid SHALL drop only after its own ready is seen, with a payload stable until then; when both have been accepted (same or different cycles), the next state SHALL be WRESP.
REQ-009 WRESP SHALL hold b_ready=1; on b_valid with b_resp=00: prog_idx+1 -> EXEC; with b_resp!=00: -> ERR, err_code=01.
REQ-010 RADDR SHALL hold ar_valid until ar_ready, then go to RRESP; RRESP SHALL hold r_ready=1.
REQ-011 On r_valid, last_rdata SHALL be set to r_data. r_resp!=00 SHALL give ERR with err_code=10. Otherwise, if (r_data & op_mask) == (op_data & op_mask): prog_idx+1, poll count=0 -> EXEC. Otherwise the poll count SHALL increment and the block SHALL return to EXEC at the same index; when the count reaches POLL_MAX, the next state SHALL be ERR with err_code=11.
REQ-012 Mask 0 SHALL always match (a plain read).
REQ-013 DELAY SHALL decrement each cycle and leave at 0. Count N SHALL cost N+1 cycles in DELAY; N=0 SHALL cost 1 cycle.
REQ-014 Advancing past entry DEPTH-1 SHALL go to DONE (no wrap).
REQ-015 On entering ERR, err_idx SHALL be set to prog_idx.
REQ-016 Flags: busy=1 in every state except IDLE/DONE/ERR; done=1 only in DONE; error=1 only in ERR.
REQ-017 At most one bus transaction SHALL be outstanding; aw/w and ar SHALL never be valid in the same cycle.
REQ-018 Write-path latency, idle responder: EXEC to aw/w_valid = 1 cycle; b_valid to next EXEC = 1 cycle.

Reset
REQ-019 rst=1 SHALL force IDLE and drop all valids/readies immediately (next edge), including mid-transaction.
REQ-020 On reset: prog_idx, err_code, err_idx, last_rdata, and the counters SHALL be 0; busy=done=error=0.
REQ-021 No outstanding-transaction recovery is required; the responder is reset together with this block.

Verification
REQ-022 Program {WRITE 0x1_0000=0xA2C, WRITE 0x1_001C=0x20, END}, responder ready always, BRESP=00 -> two writes with exactly that addr/data, done=1, prog_idx=2.
REQ-023 aw_ready delayed 3 cycles, w_ready immediate -> w_valid drops after 1 cycle, aw_valid holds 4 cycles, exactly one WRESP.
REQ-024 POLL addr 0x1_0014, mask 0x2, value 0, responder returns 0x2, 0x2, 0x0 -> 3 reads, last_rdata=0, advance to the next entry.
REQ-025 POLL_MAX=4, always-mismatching poll at index 5 -> 4 reads, then error=1, err_code=11, err_idx=5.
REQ-026 BRESP=10 on entry 1 -> error, err_code=01, err_idx=1, no further bus activity; a later start reruns from index 0.
REQ-027 rst during RRESP with ar accepted -> next cycle all valid/ready=0, state IDLE, busy=0; DELAY 0 and DELAY 3 measured at 1 and 4 cycles.
